// File: rtl/gpio_port_if.sv
// Register bus between the j1a I/O decode and a gpio_port instance.
interface gpio_port_if #(
  parameter int unsigned WIDTH = 8
);
  logic             cs;
  logic [1:0]       addr;
  logic             we;
  logic             re;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd;

  modport master (output cs, addr, we, re, wd, input rd);
  modport slave  (input cs, addr, we, re, wd, output rd);
endinterface

// File: rtl/gpio_port.sv
// Parametrised GPIO port: output data, direction, synchronised input, W1C edge events, masked irq.
// Optional per-bit input debounce is enabled by defining GPIO_DEBOUNCE_EN.
module gpio_port #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEB_BITS = 4
) (
  input  logic             clk,
  input  logic             resetq,
  gpio_port_if.slave       bus,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe,
  output logic             irq
);

  typedef enum logic [1:0] {
    REG_DATA  = 2'd0,
    REG_DIR   = 2'd1,
    REG_EVENT = 2'd2,
    REG_MASK  = 2'd3
  } reg_sel_e;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] fin;
  logic [WIDTH-1:0] fin_q;
  logic [WIDTH-1:0] event_r;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] w1c;
  logic [1:0]       warm;
  logic             wr;

  assign wr = bus.cs & bus.we;

`ifdef GPIO_DEBOUNCE_EN
  logic [DEB_BITS-1:0] cnt [WIDTH];
  logic [WIDTH-1:0]    fin_r;

  // fin flips only after the synchronised input has disagreed for 2^DEB_BITS cycles
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      fin_r <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync2[i] != fin_r[i]) begin
          if (cnt[i] == '1) begin
            fin_r[i] <= ~fin_r[i];
            cnt[i]   <= '0;
          end else begin
            cnt[i] <= cnt[i] + DEB_BITS'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign fin = fin_r;
`else
  localparam int unsigned unused_deb_bits = DEB_BITS;

  assign fin = sync2;
`endif

  // Edges are ignored until the synchroniser has flushed its reset contents
  always_comb begin
    edges = '0;
    w1c   = '0;
    if (warm == 2'd3) edges = fin ^ fin_q;
    if (wr && bus.addr == REG_EVENT) w1c = bus.wd;
  end

  always_comb begin
    bus.rd = '0;
    if (bus.cs && bus.re) begin
      case (reg_sel_e'(bus.addr))
        REG_DATA:  bus.rd = fin;
        REG_DIR:   bus.rd = pad_oe;
        REG_EVENT: bus.rd = event_r;
        REG_MASK:  bus.rd = mask_r;
        default:   bus.rd = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      sync1   <= '0;
      sync2   <= '0;
      fin_q   <= '0;
      warm    <= '0;
      event_r <= '0;
      mask_r  <= '0;
      pad_out <= '0;
      pad_oe  <= '0;
      irq     <= 1'b0;
    end else begin
      sync1 <= pad_in;
      sync2 <= sync1;
      fin_q <= fin;
      if (warm != 2'd3) warm <= warm + 2'd1;
      // A new edge overrides a same-cycle clear of that bit
      event_r <= (event_r & ~w1c) | edges;
      irq     <= |(event_r & mask_r);
      if (wr) begin
        case (reg_sel_e'(bus.addr))
          REG_DATA: pad_out <= bus.wd;
          REG_DIR:  pad_oe  <= bus.wd;
          REG_MASK: mask_r  <= bus.wd;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpio_port.sv
// Bench for gpio_port: directed scenarios plus random traffic against a pin-history reference model.
module tb_gpio_port;
  localparam int unsigned W = 8;
`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned HOLD = 16;
  localparam int unsigned LAT  = 2 + HOLD;
`else
  localparam int unsigned LAT  = 2;
`endif

  logic         clk = 1'b0;
  logic         resetq;
  logic [W-1:0] pad_in;
  logic [W-1:0] pad_out;
  logic [W-1:0] pad_oe;
  logic         irq;

  gpio_port_if #(.WIDTH(W)) bus ();

  gpio_port #(.WIDTH(W), .DEB_BITS(4)) dut (
    .clk    (clk),
    .resetq (resetq),
    .bus    (bus),
    .pad_in (pad_in),
    .pad_out(pad_out),
    .pad_oe (pad_oe),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: fin is the pad value from two clock edges ago (optionally
  // requiring a stable run of HOLD cycles); events are edges of fin after warm-up.
  logic [W-1:0] m_pad_q[$];
  logic [W-1:0] m_fin, m_fin_prev, m_event, m_mask, m_out, m_oe;
  logic         m_irq;
  int unsigned  m_age;
  int unsigned  m_run [W];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pad_q.delete();
    m_fin = '0; m_fin_prev = '0; m_event = '0; m_mask = '0;
    m_out = '0; m_oe = '0; m_irq = 1'b0; m_age = 0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  function automatic logic [W-1:0] m_rd(input logic c, input logic r, input logic [1:0] a);
    if (!(c && r)) return '0;
    case (a)
      2'd0: return m_fin;
      2'd1: return m_oe;
      2'd2: return m_event;
      default: return m_mask;
    endcase
  endfunction

  task automatic model_edge(input logic c, input logic w, input logic [1:0] a,
                            input logic [W-1:0] d, input logic [W-1:0] p);
    logic [W-1:0] nfin, edges, w1c;
`ifdef GPIO_DEBOUNCE_EN
    logic [W-1:0] seen;
    seen = (m_pad_q.size() >= 2) ? m_pad_q[1] : '0;
    nfin = m_fin;
    for (int i = 0; i < W; i++) begin
      if (seen[i] != m_fin[i]) begin
        m_run[i]++;
        if (m_run[i] == HOLD) begin
          nfin[i]  = ~m_fin[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
`else
    nfin = (m_pad_q.size() >= 1) ? m_pad_q[0] : '0;
`endif
    edges = (m_age >= 3) ? (m_fin ^ m_fin_prev) : '0;
    w1c   = (c && w && a == 2'd2) ? d : '0;
    m_irq = |(m_event & m_mask);
    m_event = (m_event & ~w1c) | edges;
    if (c && w && a == 2'd0) m_out  = d;
    if (c && w && a == 2'd1) m_oe   = d;
    if (c && w && a == 2'd3) m_mask = d;
    m_fin_prev = m_fin;
    m_fin      = nfin;
    m_pad_q.push_front(p);
    if (m_pad_q.size() > 2) void'(m_pad_q.pop_back());
    if (m_age < 3) m_age++;
  endtask

  task automatic tick(input string tag);
    logic c, w, r;
    logic [1:0] a;
    logic [W-1:0] d, p;
    #1;
    c = bus.cs; w = bus.we; r = bus.re; a = bus.addr; d = bus.wd; p = pad_in;
    chk({tag, "/rd"}, 16'(bus.rd), 16'(m_rd(c, r, a)));
    @(posedge clk);
    model_edge(c, w, a, d, p);
    #1;
    chk({tag, "/pad_out"}, 16'(pad_out), 16'(m_out));
    chk({tag, "/pad_oe"},  16'(pad_oe),  16'(m_oe));
    chk({tag, "/irq"},     16'(irq),     16'(m_irq));
  endtask

  task automatic idle();
    bus.cs = 1'b0; bus.we = 1'b0; bus.re = 1'b0; bus.addr = 2'd0; bus.wd = '0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick("idle");
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [W-1:0] d);
    bus.cs = 1'b1; bus.we = 1'b1; bus.re = 1'b0; bus.addr = a; bus.wd = d;
    tick("wr");
    idle();
  endtask

  task automatic rd_const(input logic [1:0] a, input logic [W-1:0] e, input string tag);
    bus.cs = 1'b1; bus.we = 1'b0; bus.re = 1'b1; bus.addr = a; bus.wd = '0;
    #1;
    chk(tag, 16'(bus.rd), 16'(e));
    tick(tag);
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetq = 1'b0;
    pad_in = 8'hFF;
    idle();
    model_reset();

    // Reset with pins high: no events, DATA reads the pins
    @(negedge clk);
    #1;
    chk("rst_pad_out", 16'(pad_out), 16'h0);
    chk("rst_pad_oe",  16'(pad_oe),  16'h0);
    chk("rst_irq",     16'(irq),     16'h0);
    @(negedge clk);
    resetq = 1'b1;
    run(10);
    rd_const(2'd2, 8'h00, "boot_event");
    rd_const(2'd0, 8'hFF, "boot_data");
    chk("boot_irq", 16'(irq), 16'h0);

    // Direction and data writes; cs=0 write ignored
    write_reg(2'd1, 8'h0F);
    write_reg(2'd0, 8'hA5);
    chk("dir_out", 16'(pad_oe),  16'h0F);
    chk("dat_out", 16'(pad_out), 16'hA5);
    rd_const(2'd1, 8'h0F, "dir_rd");
    bus.cs = 1'b0; bus.we = 1'b1; bus.addr = 2'd1; bus.wd = 8'hFF;
    tick("nocs");
    idle();
    chk("nocs_oe", 16'(pad_oe), 16'h0F);

    // Rising edge on bit 0 with MASK=1
    write_reg(2'd3, 8'h01);
    pad_in = 8'hFE;
    run(LAT + 3);
    write_reg(2'd2, 8'hFF);
    run(2);
    pad_in = 8'hFF;
    run(LAT + 1);
    chk("irq_lag", 16'(irq), 16'h0);
    rd_const(2'd2, 8'h01, "ev0_set");
    chk("irq_set", 16'(irq), 16'h1);
    write_reg(2'd2, 8'h01);
    chk("irq_hold", 16'(irq), 16'h1);
    rd_const(2'd2, 8'h00, "ev0_clr");
    chk("irq_clr", 16'(irq), 16'h0);

    // Simultaneous write and read returns the old value
    bus.cs = 1'b1; bus.we = 1'b1; bus.re = 1'b1; bus.addr = 2'd3; bus.wd = 8'hAA;
    #1;
    chk("wr_rd_old", 16'(bus.rd), 16'h01);
    tick("wr_rd");
    idle();
    rd_const(2'd3, 8'hAA, "wr_rd_new");
    write_reg(2'd3, 8'h01);

    // W1C on bit 3 coinciding with a new bit-3 edge: set wins
    pad_in = 8'hF7;
    run(LAT + 1);
    rd_const(2'd2, 8'h08, "ev3_set");
    pad_in = 8'hFF;
    run(LAT);
    write_reg(2'd2, 8'h08);
    rd_const(2'd2, 8'h08, "ev3_setwins");
    write_reg(2'd2, 8'hFF);

    // 10-cycle glitch on bit 2, then a 20-cycle level change
    pad_in = 8'hFB;
    run(10);
    pad_in = 8'hFF;
    run(LAT + 8);
`ifdef GPIO_DEBOUNCE_EN
    rd_const(2'd2, 8'h00, "glitch_ev");
`else
    rd_const(2'd2, 8'h04, "glitch_ev");
`endif
    write_reg(2'd2, 8'hFF);
    pad_in = 8'hFB;
    run(17);
`ifdef GPIO_DEBOUNCE_EN
    rd_const(2'd0, 8'hFF, "level_early");
`else
    rd_const(2'd0, 8'hFB, "level_early");
`endif
    rd_const(2'd0, 8'hFB, "level_fin");
    rd_const(2'd2, 8'h04, "level_ev");
    pad_in = 8'hFF;
    run(LAT + 2);
    write_reg(2'd2, 8'hFF);

    // Random bus traffic and pin activity
    for (int n = 0; n < 400; n++) begin
      bus.cs   = 1'($urandom);
      bus.we   = ($urandom_range(0, 3) == 0);
      bus.re   = 1'($urandom);
      bus.addr = 2'($urandom);
      bus.wd   = W'($urandom);
      if ($urandom_range(0, 15) == 0) pad_in = pad_in ^ W'($urandom);
      tick("rand");
    end
    idle();

    // All events pending with full mask, then reset mid-operation
    run(25);
    write_reg(2'd3, 8'hFF);
    write_reg(2'd2, 8'hFF);
    pad_in = ~pad_in;
    run(LAT + 1);
    rd_const(2'd2, 8'hFF, "all_ev");
    chk("all_irq", 16'(irq), 16'h1);
    resetq = 1'b0;
    #1;
    chk("mid_rst_out", 16'(pad_out), 16'h0);
    chk("mid_rst_oe",  16'(pad_oe),  16'h0);
    chk("mid_rst_irq", 16'(irq),     16'h0);
    bus.cs = 1'b1; bus.re = 1'b1; bus.addr = 2'd2;
    #1;
    chk("mid_rst_ev", 16'(bus.rd), 16'h0);
    idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetq = 1'b1;
    run(6);
    rd_const(2'd2, 8'h00, "warm_ev");
    run(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
